id_ex_operand_stage: RTL and testbench

//   ID/EX pipeline register plus EX operand-select/forwarding logic feeding the ALU.

---
 rtl/id_ex_operand_stage_if.sv | 80 ++++++++
 rtl/id_ex_operand_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
//   Bundle between the ID stage, the forwarding sources (EX/MEM, MEM/WB) and
//   the ALU for the ID/EX operand stage.
//
//   Handshake: an ID instruction (id_valid=1) is accepted on a rising clk
//   edge only when stall, flush and hazard_stall are all 0. When
//   hazard_stall=1 the producer must hold the same instruction on the ID
//   fields (IF/ID frozen) and re-present it on the next cycle. flush discards
//   whatever is presented; stall holds EX and also ignores ID that cycle.
//
//   modport master : ID/pipeline side (drives ID fields, stall/flush,
//                    forwarding sources; receives ALU operands and EX
//                    controls).
//   modport slave  : the operand stage itself.
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   // pipeline control
   logic              stall;
   logic              flush;
   // decoded ID fields
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [15:0]       id_imm;
   logic              id_ext_sign;
   logic              id_alu_src;
   logic [3:0]        id_alu_ctr;
   logic [REG_AW-1:0] id_dst;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   // forwarding sources
   logic              exmem_reg_write;
   logic [REG_AW-1:0] exmem_dst;
   logic [DATA_W-1:0] exmem_result;
   logic              memwb_reg_write;
   logic [REG_AW-1:0] memwb_dst;
   logic [DATA_W-1:0] memwb_result;
   // to the ALU / downstream
   logic [3:0]        alu_ctr;
   logic [DATA_W-1:0] src_1;
   logic [DATA_W-1:0] src_2;
   logic [DATA_W-1:0] ex_store_data;
   logic              ex_valid;
   logic [REG_AW-1:0] ex_dst;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              hazard_stall;

   modport master (
      output stall, flush,
      output id_valid, id_rs, id_rt, id_rs_data, id_rt_data, id_imm,
      output id_ext_sign, id_alu_src, id_alu_ctr, id_dst,
      output id_reg_write, id_mem_read, id_mem_write,
      output exmem_reg_write, exmem_dst, exmem_result,
      output memwb_reg_write, memwb_dst, memwb_result,
      input  alu_ctr, src_1, src_2, ex_store_data,
      input  ex_valid, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write,
      input  hazard_stall
   );

   modport slave (
      input  stall, flush,
      input  id_valid, id_rs, id_rt, id_rs_data, id_rt_data, id_imm,
      input  id_ext_sign, id_alu_src, id_alu_ctr, id_dst,
      input  id_reg_write, id_mem_read, id_mem_write,
      input  exmem_reg_write, exmem_dst, exmem_result,
      input  memwb_reg_write, memwb_dst, memwb_result,
      output alu_ctr, src_1, src_2, ex_store_data,
      output ex_valid, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write,
      output hazard_stall
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus EX operand selection / forwarding feeding
//   the ALU, with load-use (and, without forwarding, RAW) hazard detection.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (clears all EX registers)
//     bus    id_ex_operand_stage_if.slave: ID fields, stall/flush, EX/MEM and
//            MEM/WB forwarding sources in; alu_ctr/src_1/src_2/ex_store_data,
//            registered EX controls and combinational hazard_stall out.
//
//   Build option: ALU_FORWARD_EN
//     defined   : operands forwarded from EX/MEM (priority) then MEM/WB;
//                 hazard_stall only for load-use.
//     undefined : operands are the registered regfile data; hazard_stall
//                 also covers any RAW dependency on EX or EX/MEM.
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   id_ex_operand_stage_if.slave bus
);

   // EX-stage register contents; the all-zero value is the bubble
   // (ex_valid=0, no writes, alu_ctr=0000, operands 0).
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] dst;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm_ext;
      logic              alu_src;
      logic [3:0]        alu_ctr;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
   } ex_t;

   ex_t               ex_q, ex_d;
   logic [DATA_W-1:0] fwd_rs, fwd_rt;
   logic              rt_used;
   logic              load_use;
   logic              hazard;

   // ---------------- hazard detection ----------------
   // rt is a real source unless the instruction takes the immediate and is
   // not a store (stores always need rt as write data).
`ifdef ALU_FORWARD_EN
   always_comb begin
      rt_used  = !(bus.id_alu_src && !bus.id_mem_write);
      load_use = ex_q.valid && ex_q.mem_read && (ex_q.dst != '0) &&
                 ((ex_q.dst == bus.id_rs) || ((ex_q.dst == bus.id_rt) && rt_used));
      hazard   = bus.id_valid && load_use;
   end
`else
   logic raw_ex, raw_mem;
   always_comb begin
      rt_used  = !(bus.id_alu_src && !bus.id_mem_write);
      load_use = ex_q.valid && ex_q.mem_read && (ex_q.dst != '0) &&
                 ((ex_q.dst == bus.id_rs) || ((ex_q.dst == bus.id_rt) && rt_used));
      raw_ex   = ex_q.reg_write && (ex_q.dst != '0) &&
                 ((ex_q.dst == bus.id_rs) || ((ex_q.dst == bus.id_rt) && rt_used));
      raw_mem  = bus.exmem_reg_write && (bus.exmem_dst != '0) &&
                 ((bus.exmem_dst == bus.id_rs) || ((bus.exmem_dst == bus.id_rt) && rt_used));
      // MEM/WB is absent: the regfile writes before it is read.
      hazard   = bus.id_valid && (load_use || raw_ex || raw_mem);
   end
`endif

   // ---------------- operand forwarding ----------------
`ifdef ALU_FORWARD_EN
   always_comb begin
      // EX/MEM is newer than MEM/WB, so it wins when both match.
      fwd_rs = ex_q.rs_data;
      if (bus.exmem_reg_write && (ex_q.rs != '0) && (bus.exmem_dst == ex_q.rs))
         fwd_rs = bus.exmem_result;
      else if (bus.memwb_reg_write && (ex_q.rs != '0) && (bus.memwb_dst == ex_q.rs))
         fwd_rs = bus.memwb_result;

      fwd_rt = ex_q.rt_data;
      if (bus.exmem_reg_write && (ex_q.rt != '0) && (bus.exmem_dst == ex_q.rt))
         fwd_rt = bus.exmem_result;
      else if (bus.memwb_reg_write && (ex_q.rt != '0) && (bus.memwb_dst == ex_q.rt))
         fwd_rt = bus.memwb_result;
   end
`else
   assign fwd_rs = ex_q.rs_data;
   assign fwd_rt = ex_q.rt_data;
   // Source indices and result buses only matter when forwarding is built in.
   logic unused_fwd;
   assign unused_fwd = ^{ex_q.rs, ex_q.rt, bus.exmem_result,
                         bus.memwb_reg_write, bus.memwb_dst, bus.memwb_result};
`endif

   // ---------------- next EX contents ----------------
   // Priority: flush > stall > hazard > capture (invalid ID captures a bubble).
   always_comb begin
      ex_d = ex_q;
      if (bus.flush) begin
         ex_d = '0;
      end else if (bus.stall) begin
         ex_d = ex_q;
      end else if (hazard || !bus.id_valid) begin
         ex_d = '0;
      end else begin
         ex_d.valid     = 1'b1;
         ex_d.rs        = bus.id_rs;
         ex_d.rt        = bus.id_rt;
         ex_d.dst       = bus.id_dst;
         ex_d.rs_data   = bus.id_rs_data;
         ex_d.rt_data   = bus.id_rt_data;
         ex_d.imm_ext   = bus.id_ext_sign ? {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm}
                                          : {{(DATA_W-16){1'b0}}, bus.id_imm};
         ex_d.alu_src   = bus.id_alu_src;
         ex_d.alu_ctr   = bus.id_alu_ctr;
         ex_d.reg_write = bus.id_reg_write;
         ex_d.mem_read  = bus.id_mem_read;
         ex_d.mem_write = bus.id_mem_write;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   // ---------------- outputs ----------------
   assign bus.alu_ctr       = ex_q.alu_ctr;
   assign bus.src_1         = fwd_rs;
   assign bus.src_2         = ex_q.alu_src ? ex_q.imm_ext : fwd_rt;
   assign bus.ex_store_data = fwd_rt;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_dst        = ex_q.dst;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;
   assign bus.hazard_stall  = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Self-checking bench for id_ex_operand_stage: reset check, a table of
//   hazard-detection vectors, hand-written pipeline sequences, then random
//   stimulus scored against a behavioural instruction-level model.
//   Expectations follow the ALU_FORWARD_EN build option.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;
   localparam int DW = 32;
   localparam int AW = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_ex_operand_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
   id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic ctl(input logic s, input logic f);
      bus.stall = s;
      bus.flush = f;
   endtask

   task automatic fwd(input logic erw, input logic [4:0] ed, input logic [31:0] er,
                      input logic mrw, input logic [4:0] md, input logic [31:0] mres);
      bus.exmem_reg_write = erw; bus.exmem_dst = ed; bus.exmem_result = er;
      bus.memwb_reg_write = mrw; bus.memwb_dst = md; bus.memwb_result = mres;
   endtask

   task automatic idi(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [15:0] imm, input logic ext, input logic asrc,
                      input logic [3:0] ctr, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic mw);
      bus.id_valid = 1'b1;
      bus.id_rs = rs; bus.id_rt = rt; bus.id_rs_data = rsd; bus.id_rt_data = rtd;
      bus.id_imm = imm; bus.id_ext_sign = ext; bus.id_alu_src = asrc;
      bus.id_alu_ctr = ctr; bus.id_dst = dst;
      bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
   endtask

   task automatic id_idle();
      idi(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
      bus.id_valid = 1'b0;
   endtask

   // ---------------- hazard vector table ----------------
   // An instruction (load or not, writing ex_dst or not) is put into EX,
   // then an ID instruction plus EX/MEM state is presented; MEM/WB always
   // targets id_rs and must never cause a hazard.
   typedef struct {
      logic       ex_load;
      logic       ex_rw;
      logic [4:0] ex_dst;
      logic       id_valid;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_alu_src;
      logic       id_mem_write;
      logic       exmem_rw;
      logic [4:0] exmem_dst;
      logic       exp_fwd;
      logic       exp_nofwd;
   } haz_vec_t;

   haz_vec_t vecs[$];

   task automatic add_vec(input logic el, input logic er, input logic [4:0] ed,
                          input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                          input logic as, input logic mw, input logic xw,
                          input logic [4:0] xd, input logic ef, input logic en);
      haz_vec_t v;
      v.ex_load = el; v.ex_rw = er; v.ex_dst = ed; v.id_valid = iv;
      v.id_rs = rs; v.id_rt = rt; v.id_alu_src = as; v.id_mem_write = mw;
      v.exmem_rw = xw; v.exmem_dst = xd; v.exp_fwd = ef; v.exp_nofwd = en;
      vecs.push_back(v);
   endtask

   // ---------------- behavioural reference model ----------------
   // The model tracks "which instruction sits in EX" as a record and derives
   // every output from the stage's rules applied to that record.
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, dst;
      logic [31:0] a, b, imm;
      logic        alu_src;
      logic [3:0]  ctr;
      logic        rw, mr, mw;
   } m_ex_t;

   m_ex_t m;

   function automatic logic [31:0] m_operand(input logic [4:0] idx, input logic [31:0] regval);
      logic [31:0] v;
      v = regval;
`ifdef ALU_FORWARD_EN
      if (idx != 0 && bus.memwb_reg_write && bus.memwb_dst == idx) v = bus.memwb_result;
      if (idx != 0 && bus.exmem_reg_write && bus.exmem_dst == idx) v = bus.exmem_result;
`else
      if (idx == 5'd31 && 1'b0) v = 0;
`endif
      return v;
   endfunction

   // Does the presented ID instruction read register r?
   function automatic logic m_reads(input logic [4:0] r);
      return bus.id_valid && r != 0 &&
             (bus.id_rs == r || (bus.id_rt == r && !(bus.id_alu_src && !bus.id_mem_write)));
   endfunction

   function automatic logic m_hazard();
      logic h;
      h = m.valid && m.mr && m_reads(m.dst);
`ifndef ALU_FORWARD_EN
      h = h || (m.rw && m_reads(m.dst)) || (bus.exmem_reg_write && m_reads(bus.exmem_dst));
`endif
      return h;
   endfunction

   function automatic m_ex_t m_next();
      m_ex_t n;
      n = '0;
      if (bus.flush) n = '0;
      else if (bus.stall) n = m;
      else if (m_hazard() || !bus.id_valid) n = '0;
      else begin
         n.valid = 1'b1; n.rs = bus.id_rs; n.rt = bus.id_rt; n.dst = bus.id_dst;
         n.a = bus.id_rs_data; n.b = bus.id_rt_data;
         n.imm = {16'h0000, bus.id_imm};
         if (bus.id_ext_sign && bus.id_imm[15]) n.imm = n.imm + 32'hFFFF0000;
         n.alu_src = bus.id_alu_src; n.ctr = bus.id_alu_ctr;
         n.rw = bus.id_reg_write; n.mr = bus.id_mem_read; n.mw = bus.id_mem_write;
      end
      return n;
   endfunction

   task automatic m_expect();
      logic [31:0] rtv;
      rtv = m_operand(m.rt, m.b);
      exp_q.push_back({31'd0, m_hazard()});
      exp_q.push_back({31'd0, m.valid});
      exp_q.push_back({28'd0, m.ctr});
      exp_q.push_back(m_operand(m.rs, m.a));
      exp_q.push_back(m.alu_src ? m.imm : rtv);
      exp_q.push_back(rtv);
      exp_q.push_back({27'd0, m.dst});
      exp_q.push_back({31'd0, m.rw});
      exp_q.push_back({31'd0, m.mr});
      exp_q.push_back({31'd0, m.mw});
   endtask

   task automatic rand_inputs();
      logic [3:0] ctr_tab[7];
      ctr_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0011, 4'b0100};
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.id_valid = ($urandom_range(0, 7) != 0);
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_dst = 5'($urandom_range(0, 3));
      bus.id_rs_data = $urandom;
      bus.id_rt_data = $urandom;
      bus.id_imm = 16'($urandom);
      bus.id_ext_sign = 1'($urandom);
      bus.id_alu_src = 1'($urandom);
      bus.id_alu_ctr = ctr_tab[$urandom_range(0, 6)];
      bus.id_reg_write = ($urandom_range(0, 3) != 0);
      bus.id_mem_read = ($urandom_range(0, 3) == 0);
      bus.id_mem_write = ($urandom_range(0, 5) == 0);
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_dst = 5'($urandom_range(0, 3));
      bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_dst = 5'($urandom_range(0, 3));
      bus.memwb_result = $urandom;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- main test ----------------
   initial begin
      logic [31:0] act[10];
      string nm[10];
      logic [31:0] e;
      m_ex_t nxt;
      nm = '{"haz", "ex_valid", "alu_ctr", "src_1", "src_2", "store", "ex_dst",
             "ex_rw", "ex_mr", "ex_mw"};

      // reset state
      ctl(0, 0); fwd(0, 0, 0, 0, 0, 0); id_idle();
      #11;
      chk("rst_ex_valid", {31'd0, bus.ex_valid}, 0);
      chk("rst_alu_ctr", {28'd0, bus.alu_ctr}, 0);
      chk("rst_src_1", bus.src_1, 0);
      chk("rst_src_2", bus.src_2, 0);
      chk("rst_ex_dst", {27'd0, bus.ex_dst}, 0);
      chk("rst_haz", {31'd0, bus.hazard_stall}, 0);
      #1 rst_n = 1'b1;
      step();

      // hazard table
      add_vec(1, 1, 5, 1, 5, 0, 0, 0, 0, 0, 1, 1);  // load-use on rs
      add_vec(1, 1, 5, 1, 1, 5, 0, 0, 0, 0, 1, 1);  // load-use on rt (R-type)
      add_vec(1, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0);  // rt is immediate dest, unused
      add_vec(1, 1, 5, 1, 1, 5, 1, 1, 0, 0, 1, 1);  // store reads rt
      add_vec(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // $0 never hazards
      add_vec(1, 1, 5, 0, 5, 5, 0, 0, 0, 0, 0, 0);  // invalid ID
      add_vec(0, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0, 1);  // ALU RAW on EX
      add_vec(0, 0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0);  // EX does not write
      add_vec(0, 1, 6, 1, 1, 2, 0, 0, 1, 2, 0, 1);  // RAW on EX/MEM via rt
      add_vec(0, 1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);  // EX/MEM to $0
      add_vec(0, 1, 6, 1, 3, 4, 0, 0, 0, 3, 0, 0);  // EX/MEM not writing
      add_vec(0, 1, 6, 1, 4, 6, 1, 0, 0, 0, 0, 0);  // addi-style rt unused
      add_vec(0, 1, 6, 1, 4, 6, 1, 1, 0, 0, 0, 1);  // store rt on ALU result
      foreach (vecs[i]) begin
         ctl(0, 0); fwd(0, 0, 0, 0, 0, 0); id_idle();
         step();
         idi(0, 0, 0, 0, 0, 0, 0, 4'b0010, vecs[i].ex_dst, vecs[i].ex_rw, vecs[i].ex_load, 0);
         step();
         idi(vecs[i].id_rs, vecs[i].id_rt, 1, 2, 16'h0004, 0, vecs[i].id_alu_src,
             4'b0010, 5'd20, 1, 0, vecs[i].id_mem_write);
         bus.id_valid = vecs[i].id_valid;
         fwd(vecs[i].exmem_rw, vecs[i].exmem_dst, 32'h1234, 1, vecs[i].id_rs, 32'h5678);
         settle();
         chk($sformatf("vec%0d_ex_mr", i), {31'd0, bus.ex_mem_read}, {31'd0, vecs[i].ex_load});
`ifdef ALU_FORWARD_EN
         chk($sformatf("vec%0d_haz", i), {31'd0, bus.hazard_stall}, {31'd0, vecs[i].exp_fwd});
`else
         chk($sformatf("vec%0d_haz", i), {31'd0, bus.hazard_stall}, {31'd0, vecs[i].exp_nofwd});
`endif
      end
      ctl(0, 0); fwd(0, 0, 0, 0, 0, 0); id_idle();
      step();

      // add $3,$1,$2 ; sub $4,$3,$1
      idi(1, 2, 5, 7, 0, 0, 0, 4'b0010, 3, 1, 0, 0); settle();
      chk("a_add_haz", {31'd0, bus.hazard_stall}, 0);
      step();
      idi(3, 1, 0, 5, 0, 0, 0, 4'b0110, 4, 1, 0, 0); settle();
      chk("a_add_src1", bus.src_1, 5);
      chk("a_add_src2", bus.src_2, 7);
      chk("a_add_ctr", {28'd0, bus.alu_ctr}, 4'b0010);
`ifdef ALU_FORWARD_EN
      chk("a_sub_haz", {31'd0, bus.hazard_stall}, 0);
      step();
      fwd(1, 3, 12, 0, 0, 0); settle();
`else
      chk("a_raw_ex_haz", {31'd0, bus.hazard_stall}, 1);
      step(); settle();
      chk("a_bubble_valid", {31'd0, bus.ex_valid}, 0);
      fwd(1, 3, 12, 0, 0, 0); settle();
      chk("a_raw_mem_haz", {31'd0, bus.hazard_stall}, 1);
      step();
      fwd(0, 0, 0, 1, 3, 12);
      idi(3, 1, 12, 5, 0, 0, 0, 4'b0110, 4, 1, 0, 0); settle();
      chk("a_wb_haz", {31'd0, bus.hazard_stall}, 0);
      step();
      fwd(0, 0, 0, 0, 0, 0); settle();
`endif
      chk("a_sub_src1", bus.src_1, 12);
      chk("a_sub_src2", bus.src_2, 5);
      chk("a_sub_ctr", {28'd0, bus.alu_ctr}, 4'b0110);
      chk("a_sub_valid", {31'd0, bus.ex_valid}, 1);
      id_idle(); fwd(0, 0, 0, 0, 0, 0);
      step();

      // EX/MEM and MEM/WB both write $3: EX/MEM wins; $0 never forwarded
      idi(3, 0, 32'h99, 0, 0, 0, 0, 4'b0000, 8, 1, 0, 0);
      step();
      fwd(1, 3, 32'h10, 1, 3, 32'h20); settle();
`ifdef ALU_FORWARD_EN
      chk("b_tie_src1", bus.src_1, 32'h10);
`else
      chk("b_tie_src1", bus.src_1, 32'h99);
`endif
      fwd(0, 3, 32'h10, 1, 3, 32'h20); settle();
`ifdef ALU_FORWARD_EN
      chk("b_wb_src1", bus.src_1, 32'h20);
`else
      chk("b_wb_src1", bus.src_1, 32'h99);
`endif
      fwd(1, 0, 32'h77, 1, 0, 32'h88); settle();
      chk("b_r0_store", bus.ex_store_data, 0);
      id_idle(); fwd(0, 0, 0, 0, 0, 0);
      step();

      // lw $5,0($1) ; or $6,$5,$2
      idi(1, 5, 100, 0, 0, 1, 1, 4'b0010, 5, 1, 1, 0); settle();
      chk("c_lw_haz", {31'd0, bus.hazard_stall}, 0);
      step();
      idi(5, 2, 0, 7, 0, 0, 0, 4'b0001, 6, 1, 0, 0); settle();
      chk("c_lu_haz", {31'd0, bus.hazard_stall}, 1);
      step(); settle();
      chk("c_bubble_valid", {31'd0, bus.ex_valid}, 0);
      fwd(1, 5, 100, 0, 0, 0); settle();
`ifdef ALU_FORWARD_EN
      chk("c_after_haz", {31'd0, bus.hazard_stall}, 0);
      step();
      fwd(0, 0, 0, 1, 5, 32'hCAFE); settle();
`else
      chk("c_after_haz", {31'd0, bus.hazard_stall}, 1);
      step();
      fwd(0, 0, 0, 1, 5, 32'hCAFE);
      idi(5, 2, 32'hCAFE, 7, 0, 0, 0, 4'b0001, 6, 1, 0, 0); settle();
      chk("c_wb_haz", {31'd0, bus.hazard_stall}, 0);
      step();
      fwd(0, 0, 0, 0, 0, 0); settle();
`endif
      chk("c_src1", bus.src_1, 32'hCAFE);
      chk("c_src2", bus.src_2, 7);
      chk("c_ctr", {28'd0, bus.alu_ctr}, 4'b0001);
      chk("c_valid", {31'd0, bus.ex_valid}, 1);
      id_idle(); fwd(0, 0, 0, 0, 0, 0);
      step();

      // flush+stall together, then stall alone
      idi(1, 2, 3, 4, 0, 0, 0, 4'b0010, 9, 1, 0, 0);
      step(); settle();
      chk("d_x_valid", {31'd0, bus.ex_valid}, 1);
      ctl(1, 1);
      idi(10, 11, 20, 5, 0, 0, 0, 4'b0110, 12, 1, 0, 0);
      step(); settle();
      chk("d_fs_valid", {31'd0, bus.ex_valid}, 0);
      chk("d_fs_ctr", {28'd0, bus.alu_ctr}, 0);
      chk("d_fs_rw", {31'd0, bus.ex_reg_write}, 0);
      ctl(0, 0);
      step(); settle();
      chk("d_y_valid", {31'd0, bus.ex_valid}, 1);
      chk("d_y_dst", {27'd0, bus.ex_dst}, 12);
      ctl(1, 0);
      idi(13, 0, 1, 0, 0, 0, 0, 4'b0001, 14, 1, 0, 0);
      step(); settle();
      chk("d_st_dst", {27'd0, bus.ex_dst}, 12);
      chk("d_st_src1", bus.src_1, 20);
      chk("d_st_ctr", {28'd0, bus.alu_ctr}, 4'b0110);
      chk("d_st_valid", {31'd0, bus.ex_valid}, 1);
      ctl(0, 0);

      // lui $7,0x8001 sign- and zero-extended
      idi(0, 7, 0, 0, 16'h8001, 1, 1, 4'b0100, 7, 1, 0, 0);
      step(); settle();
      chk("e_lui_src2", bus.src_2, 32'hFFFF8001);
      chk("e_lui_ctr", {28'd0, bus.alu_ctr}, 4'b0100);
      chk("e_lui_src1", bus.src_1, 0);
      idi(0, 7, 0, 0, 16'h8001, 0, 1, 4'b0100, 7, 1, 0, 0);
      step(); settle();
      chk("e_zext_src2", bus.src_2, 32'h00008001);

      // asynchronous reset mid-stream
      idi(1, 2, 55, 0, 0, 0, 0, 4'b0110, 9, 1, 0, 0);
      step(); settle();
      chk("f_valid", {31'd0, bus.ex_valid}, 1);
      chk("f_src1", bus.src_1, 55);
      rst_n = 1'b0;
      #1;
      chk("f_rst_valid", {31'd0, bus.ex_valid}, 0);
      chk("f_rst_ctr", {28'd0, bus.alu_ctr}, 0);
      chk("f_rst_src1", bus.src_1, 0);
      id_idle(); fwd(0, 0, 0, 0, 0, 0);
      step(); step();
      m = '0;
      rst_n = 1'b1;

      // random stimulus against the model
      for (int it = 0; it < 1500; it++) begin
         rand_inputs();
         settle();
         m_expect();
         act[0] = {31'd0, bus.hazard_stall};
         act[1] = {31'd0, bus.ex_valid};
         act[2] = {28'd0, bus.alu_ctr};
         act[3] = bus.src_1;
         act[4] = bus.src_2;
         act[5] = bus.ex_store_data;
         act[6] = {27'd0, bus.ex_dst};
         act[7] = {31'd0, bus.ex_reg_write};
         act[8] = {31'd0, bus.ex_mem_read};
         act[9] = {31'd0, bus.ex_mem_write};
         for (int k = 0; k < 10; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("rnd%0d_%s", it, nm[k]), act[k], e);
         end
         nxt = m_next();
         @(posedge clk);
         m = nxt;
         #2;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
